// File: rtl/cw310_crypto_seq.sv
// Crypto-domain sequencer: go pulse -> optional key expansion -> encrypt -> done; CRYPTO_SEQ_CYCLECNT_EN adds RUN-length measurement.
// Latency: core_init_o 1 cycle after start (key reused) or 1 cycle after key ready; done_o 1 cycle after core done.
// Backpressure: none; a start while busy is dropped and flagged in overrun_o, a stalled core is aborted by the watchdog.
module cw310_crypto_seq #(
    parameter int pKEY_WIDTH     = 128,
    parameter int pPT_WIDTH      = 128,
    parameter int pCT_WIDTH      = 128,
    parameter int pTIMEOUT_WIDTH = 16,
    parameter logic [pTIMEOUT_WIDTH-1:0] pTIMEOUT = 16'hFFFF
) (
    input  logic                      crypto_clk,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [pKEY_WIDTH-1:0]     key_i,
    input  logic [pPT_WIDTH-1:0]      textin_i,
    output logic [pKEY_WIDTH-1:0]     core_key_o,
    output logic [pPT_WIDTH-1:0]      core_text_o,
    output logic                      core_key_init_o,
    input  logic                      core_key_ready_i,
    output logic                      core_init_o,
    input  logic                      core_done_i,
    input  logic [pCT_WIDTH-1:0]      core_result_i,
    output logic [pCT_WIDTH-1:0]      cipherout_o,
    output logic [pPT_WIDTH-1:0]      textout_o,
    output logic                      done_o,
    output logic                      busy_o,
    output logic                      ready_o,
    output logic                      trig_o,
    output logic                      err_o,
    output logic                      overrun_o,
    output logic [pTIMEOUT_WIDTH-1:0] cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYINIT,
        S_KEYWAIT,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [pTIMEOUT_WIDTH-1:0] WD_LIMIT = pTIMEOUT - 1'b1;

    state_t                    state;
    state_t                    state_nx;
    logic                      key_valid;
    logic [pTIMEOUT_WIDTH-1:0] wdog;
    logic                      accept;
    logic                      timeout;
    logic                      wd_hit;

    assign wd_hit = (wdog == WD_LIMIT);

    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Completion is tested before the watchdog so a done/ready on the limit cycle still succeeds.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        timeout  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    accept   = 1'b1;
                    state_nx = (!key_valid || (key_i != core_key_o)) ? S_KEYINIT : S_INIT;
                end
            end
            S_KEYINIT: state_nx = S_KEYWAIT;
            S_KEYWAIT: begin
                if (core_key_ready_i) begin
                    state_nx = S_INIT;
                end else if (wd_hit) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_INIT: state_nx = S_RUN;
            S_RUN: begin
                if (core_done_i) begin
                    state_nx = S_DONE;
                end else if (wd_hit) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign ready_o = (state == S_IDLE);
    assign busy_o  = !ready_o;
    assign trig_o  = (state == S_INIT) || (state == S_RUN);

    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            key_valid       <= 1'b0;
            core_key_o      <= '0;
            core_text_o     <= '0;
            cipherout_o     <= '0;
            textout_o       <= '0;
            err_o           <= 1'b0;
            overrun_o       <= 1'b0;
            wdog            <= '0;
            core_key_init_o <= 1'b0;
            core_init_o     <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            core_key_init_o <= (state_nx == S_KEYINIT);
            core_init_o     <= (state_nx == S_INIT);
            done_o          <= (state_nx == S_DONE);

            if (accept) begin
                core_key_o  <= key_i;
                core_text_o <= textin_i;
                err_o       <= 1'b0;
                overrun_o   <= 1'b0;
            end else if (start_i) begin
                overrun_o   <= 1'b1;
            end

            if (timeout) begin
                err_o     <= 1'b1;
                key_valid <= 1'b0;
            end else if ((state == S_KEYWAIT) && core_key_ready_i) begin
                key_valid <= 1'b1;
            end

            if ((state == S_RUN) && core_done_i) begin
                cipherout_o <= core_result_i;
                textout_o   <= core_text_o;
            end

            // KEYINIT and INIT always precede the two wait states, so clearing there gives count 0 on entry.
            if ((state == S_KEYINIT) || (state == S_INIT)) begin
                wdog <= '0;
            end else if ((state == S_KEYWAIT) || (state == S_RUN)) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

`ifdef CRYPTO_SEQ_CYCLECNT_EN
    logic [pTIMEOUT_WIDTH-1:0] run_cnt;

    // run_cnt holds the RUN cycles before the current one; the done cycle itself adds one.
    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_cnt  <= '0;
            cycles_o <= '0;
        end else begin
            if (state == S_INIT) begin
                run_cnt <= '0;
            end else if ((state == S_RUN) && (run_cnt != '1)) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if ((state == S_RUN) && core_done_i) begin
                cycles_o <= (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
            end
        end
    end
`else
    assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_cw310_crypto_seq.sv
// Directed bench: main instance with default watchdog, second instance with an 8-cycle watchdog.
module tb_cw310_crypto_seq;

`ifdef CRYPTO_SEQ_CYCLECNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T3 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] text = '0;
    logic [127:0] result = '0;

    logic         start = 1'b0, key_ready = 1'b0, done_in = 1'b0;
    logic [127:0] core_key, core_text, cipher, textout;
    logic         key_init, init, done, busy, ready, trig, err, overrun;
    logic [15:0]  cycles;

    logic         start8 = 1'b0, key_ready8 = 1'b0, done_in8 = 1'b0;
    logic [127:0] core_key8, core_text8, cipher8, textout8;
    logic         key_init8, init8, done8, busy8, ready8, trig8, err8, overrun8;
    logic [15:0]  cycles8;

    int n_tests = 0;
    int n_fail  = 0;
    int key_init_cnt = 0, init_cnt = 0, done_cnt = 0, done8_cnt = 0;

    always #5 clk = ~clk;

    cw310_crypto_seq dut (
        .crypto_clk(clk), .reset_n_i(rst_n), .start_i(start), .key_i(key), .textin_i(text),
        .core_key_o(core_key), .core_text_o(core_text), .core_key_init_o(key_init),
        .core_key_ready_i(key_ready), .core_init_o(init), .core_done_i(done_in),
        .core_result_i(result), .cipherout_o(cipher), .textout_o(textout), .done_o(done),
        .busy_o(busy), .ready_o(ready), .trig_o(trig), .err_o(err), .overrun_o(overrun),
        .cycles_o(cycles)
    );

    cw310_crypto_seq #(.pTIMEOUT(16'd8)) dut8 (
        .crypto_clk(clk), .reset_n_i(rst_n), .start_i(start8), .key_i(key), .textin_i(text),
        .core_key_o(core_key8), .core_text_o(core_text8), .core_key_init_o(key_init8),
        .core_key_ready_i(key_ready8), .core_init_o(init8), .core_done_i(done_in8),
        .core_result_i(result), .cipherout_o(cipher8), .textout_o(textout8), .done_o(done8),
        .busy_o(busy8), .ready_o(ready8), .trig_o(trig8), .err_o(err8), .overrun_o(overrun8),
        .cycles_o(cycles8)
    );

    always @(negedge clk) begin
        if (key_init) key_init_cnt++;
        if (init)     init_cnt++;
        if (done)     done_cnt++;
        if (done8)    done8_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on the main instance; ovr_at >= 0 pulses a second start in that RUN cycle.
    task automatic do_op(input string tag, input logic [127:0] k, input logic [127:0] t,
                         input logic [127:0] c, input bit reload, input int kw, input int rc,
                         input int ovr_at);
        int ki0 = key_init_cnt;
        int i0  = init_cnt;
        int d0  = done_cnt;
        key = k; text = t; start = 1'b1;
        step();
        start = 1'b0;
        check({tag, ".key_init_c1"}, key_init, reload);
        check({tag, ".busy_c1"}, busy, 1'b1);
        check({tag, ".core_key"}, core_key, k);
        check({tag, ".core_text"}, core_text, t);
        check({tag, ".flags_cleared"}, {err, overrun}, 2'b00);
        if (reload) begin
            step();
            for (int i = 0; i < kw; i++) begin
                if (i == kw - 1) begin
                    key_ready = 1'b1;
                    check({tag, ".no_init_in_keywait"}, init, 1'b0);
                end else begin
                    step();
                end
            end
            step();
            key_ready = 1'b0;
        end
        check({tag, ".core_init"}, init, 1'b1);
        check({tag, ".trig_init"}, trig, 1'b1);
        for (int i = 0; i < rc; i++) begin
            step();
            start = (i == ovr_at);
            if (start) begin
                key = ~k; text = ~t;
            end
            check({tag, ".trig_run"}, {trig, busy, done}, 3'b110);
            if (i == rc - 1) begin
                done_in = 1'b1; result = c;
            end
        end
        step();
        start = 1'b0; done_in = 1'b0; result = ~c;
        check({tag, ".done_o"}, done, 1'b1);
        check({tag, ".busy_done"}, busy, 1'b1);
        check({tag, ".cipherout"}, cipher, c);
        check({tag, ".textout"}, textout, t);
        check({tag, ".core_key_kept"}, core_key, k);
        check({tag, ".cycles"}, cycles, CNT_EN ? rc : 0);
        check({tag, ".overrun"}, overrun, (ovr_at >= 0));
        check({tag, ".err"}, err, 1'b0);
        step();
        check({tag, ".idle_after"}, {ready, busy, done, trig}, 4'b1000);
        check({tag, ".done_pulses"}, done_cnt - d0, 1);
        check({tag, ".init_pulses"}, init_cnt - i0, 1);
        check({tag, ".key_init_pulses"}, key_init_cnt - ki0, reload);
        check({tag, ".cipher_hold"}, cipher, c);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d8;
        #1;
        check("rst.ready_busy", {ready, busy}, 2'b10);
        check("rst.pulses", {key_init, init, done, trig}, 4'b0000);
        check("rst.flags", {err, overrun}, 2'b00);
        check("rst.core_key", core_key, '0);
        check("rst.cipher", cipher, '0);
        check("rst.cycles", cycles, '0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        do_op("op1", K1, T1, C1, 1'b1, 3, 10, -1);
        do_op("op2_reuse", K1, T2, C2, 1'b0, 0, 10, -1);
        do_op("op3_overrun", K1, T3, C3, 1'b0, 0, 6, 2);
        do_op("op4_newkey", K2, T1, C2, 1'b1, 1, 4, -1);

        // Watchdog abort in RUN on the 8-cycle instance.
        d8 = done8_cnt;
        key = K1; text = T1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        check("to.key_init", key_init8, 1'b1);
        step();
        key_ready8 = 1'b1;
        step();
        key_ready8 = 1'b0;
        check("to.init", init8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("to.err_before_limit", {err8, busy8}, 2'b01);
        end
        step();
        check("to.err_set", err8, 1'b1);
        check("to.idle", {ready8, busy8, trig8}, 3'b100);
        check("to.no_done", done8_cnt - d8, 0);
        check("to.cipher_unchanged", cipher8, '0);
        check("to.cycles_unchanged", cycles8, '0);

        // Same key must reload after the abort; done on the limit cycle wins.
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        check("to2.key_reload", key_init8, 1'b1);
        check("to2.err_cleared", err8, 1'b0);
        step();
        key_ready8 = 1'b1;
        step();
        key_ready8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) begin
                done_in8 = 1'b1; result = C2;
            end
        end
        step();
        done_in8 = 1'b0; result = '0;
        check("to2.done_at_limit", done8, 1'b1);
        check("to2.no_err", err8, 1'b0);
        check("to2.cipher", cipher8, C2);
        check("to2.textout", textout8, T1);
        check("to2.cycles", cycles8, CNT_EN ? 8 : 0);
        step();

        // Reset asserted while waiting for key expansion.
        key = K2; text = T2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("mid.in_keywait", {busy, key_init, init}, 3'b100);
        rst_n = 1'b0;
        #1;
        check("mid.ready_busy", {ready, busy}, 2'b10);
        check("mid.pulses", {key_init, init, done, trig}, 4'b0000);
        check("mid.core_key", core_key, '0);
        check("mid.core_text", core_text, '0);
        check("mid.cipher", cipher, '0);
        check("mid.textout", textout, '0);
        check("mid.flags", {err, overrun}, 2'b00);
        check("mid.cycles", cycles, '0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        do_op("after_rst", K2, T3, C3, 1'b1, 2, 4, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
